// File: rtl/tof_i2c_arbiter.sv
// Round-robin arbiter that lets eight ToF sensor FSMs share one I2C master.
// One transaction per grant; each grant is followed by a release cycle before re-arbitration.
module tof_i2c_arbiter #(
    parameter int N_REQ       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rnw,
    input  logic [7*N_REQ-1:0]   req_dev_addr,
    input  logic [16*N_REQ-1:0]  req_reg_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [7:0]           rdata,
    output logic [2:0]           cur_owner,
    output logic                 m_start,
    output logic                 m_rnw,
    output logic [6:0]           m_dev_addr,
    output logic [15:0]          m_reg_addr,
    output logic [7:0]           m_wdata,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               m_start_q, m_start_d;
    logic               m_rnw_q, m_rnw_d;
    logic [6:0]         m_dev_addr_q, m_dev_addr_d;
    logic [15:0]        m_reg_addr_q, m_reg_addr_d;
    logic [7:0]         m_wdata_q, m_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         cand;
    logic [N_REQ-1:0]   win_oh;
    logic               timeout_hit;

    // Search upward from ptr, wrapping, so the last owner ends up at lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 3'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_found) state_d = S_START;
            S_START:   if (!m_busy) state_d = S_WAIT;
            S_WAIT:    if (m_done || timeout_hit) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Owner mask is gnt_q, so done/err can only ever hit the granted bit.
    always_comb begin
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        rdata_d      = rdata_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        m_start_d    = 1'b0;
        m_rnw_d      = m_rnw_q;
        m_dev_addr_d = m_dev_addr_q;
        m_reg_addr_d = m_reg_addr_q;
        m_wdata_d    = m_wdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d        = win_oh;
                    owner_d      = win_idx;
                    m_rnw_d      = req_rnw[win_idx];
                    m_dev_addr_d = req_dev_addr[7*win_idx +: 7];
                    m_reg_addr_d = req_reg_addr[16*win_idx +: 16];
                    m_wdata_d    = req_wdata[8*win_idx +: 8];
                    cnt_d        = '0;
                end
            end
            S_START: begin
                if (!m_busy) begin
                    m_start_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                // A completion landing on the last counted cycle wins over the timeout.
                if (m_done) begin
                    done_d = gnt_q;
                    err_d  = m_ack_err ? gnt_q : '0;
                    if (m_rnw_q) rdata_d = m_rdata;
                end else if (timeout_hit) begin
                    done_d = gnt_q;
                    err_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                gnt_d = '0;
                ptr_d = 3'((int'(owner_q) + 1) % N_REQ);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            m_start_q    <= 1'b0;
            m_rnw_q      <= 1'b0;
            m_dev_addr_q <= '0;
            m_reg_addr_q <= '0;
            m_wdata_q    <= '0;
            cnt_q        <= '0;
        end else begin
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            m_start_q    <= m_start_d;
            m_rnw_q      <= m_rnw_d;
            m_dev_addr_q <= m_dev_addr_d;
            m_reg_addr_q <= m_reg_addr_d;
            m_wdata_q    <= m_wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign cur_owner  = owner_q;
    assign m_start    = m_start_q;
    assign m_rnw      = m_rnw_q;
    assign m_dev_addr = m_dev_addr_q;
    assign m_reg_addr = m_reg_addr_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Self-checking bench for tof_i2c_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_tof_i2c_arbiter;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req, req_rnw;
    logic [55:0]  req_dev_addr;
    logic [127:0] req_reg_addr;
    logic [63:0]  req_wdata;
    logic [7:0]   gnt, done, err, rdata;
    logic [2:0]   cur_owner;
    logic         m_start, m_rnw;
    logic [6:0]   m_dev_addr;
    logic [15:0]  m_reg_addr;
    logic [7:0]   m_wdata;
    logic         m_busy, m_done, m_ack_err;
    logic [7:0]   m_rdata;

    always #5 clk = ~clk;

    tof_i2c_arbiter #(.N_REQ(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rnw(req_rnw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .cur_owner(cur_owner),
        .m_start(m_start), .m_rnw(m_rnw), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
        .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err),
        .m_rdata(m_rdata)
    );

    int checks = 0;
    int passes = 0;
    int start_pulses = 0;
    int inv_bad = 0;
    int mdl_ptr = 0;
    logic [7:0] mdl_rdata = 8'h00;

    logic        f_rnw [8];
    logic [6:0]  f_dev [8];
    logic [15:0] f_reg [8];
    logic [7:0]  f_wd  [8];

    always @(negedge clk) begin
        if (m_start) start_pulses++;
        if (rst_n && (!$onehot0(gnt) || ((done & ~gnt) != 0) || ((err & ~gnt) != 0))) inv_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requesting index at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < 8; i++) begin
            req_rnw[i]             = f_rnw[i];
            req_dev_addr[7*i +: 7] = f_dev[i];
            req_reg_addr[16*i +: 16] = f_reg[i];
            req_wdata[8*i +: 8]    = f_wd[i];
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 8; i++) begin
            f_rnw[i] = 1'($urandom);
            f_dev[i] = 7'($urandom);
            f_reg[i] = 16'($urandom);
            f_wd[i]  = 8'($urandom);
        end
        drive_fields();
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (gnt != 0) begin cyc = i; break; end
        end
    endtask

    task automatic wait_start(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m_start) begin cyc = i; break; end
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done != 0) begin cyc = i; break; end
        end
    endtask

    task automatic finish_done(input logic ack, input logic [7:0] rd);
        m_done = 1'b1; m_ack_err = ack; m_rdata = rd;
        step();
        m_done = 1'b0; m_ack_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
        rand_fields();
        repeat (3) step();
        checks++; if (gnt !== 8'h00) $display("FAIL reset_gnt: got %h expected 00", gnt); else passes++;
        checks++; if ({done, err} !== 16'h0) $display("FAIL reset_done_err: got %h expected 0000", {done, err}); else passes++;
        checks++; if ({rdata, cur_owner} !== 11'h0) $display("FAIL reset_rdata_owner: got %h expected 0", {rdata, cur_owner}); else passes++;
        checks++; if ({m_start, m_rnw, m_dev_addr, m_reg_addr, m_wdata} !== 33'h0)
            $display("FAIL reset_master_cmd: got %h expected 0", {m_start, m_rnw, m_dev_addr, m_reg_addr, m_wdata}); else passes++;
        req = 8'h00; rst_n = 1'b1;
        step();
        checks++; if (gnt !== 8'h00) $display("FAIL reset_no_req_gnt: got %h expected 00", gnt); else passes++;
        mdl_ptr = 0; mdl_rdata = 8'h00;
    endtask

    task automatic test_single();
        int s0;
        rand_fields();
        f_rnw[0] = 1'b1; f_dev[0] = 7'h29; f_reg[0] = 16'h0000;
        drive_fields();
        s0 = start_pulses;
        req = 8'h01;
        step();
        checks++; if (gnt !== 8'h01) $display("FAIL single_gnt_latency: got %h expected 01", gnt); else passes++;
        checks++; if ({m_start, m_rnw, m_dev_addr, m_reg_addr, cur_owner} !== {1'b0, 1'b1, 7'h29, 16'h0000, 3'd0})
            $display("FAIL single_cmd: got %h expected %h", {m_start, m_rnw, m_dev_addr, m_reg_addr, cur_owner},
                     {1'b0, 1'b1, 7'h29, 16'h0000, 3'd0}); else passes++;
        step();
        checks++; if (m_start !== 1'b1) $display("FAIL single_start_latency: got %b expected 1", m_start); else passes++;
        step();
        checks++; if (m_start !== 1'b0) $display("FAIL single_start_width: got %b expected 0", m_start); else passes++;
        finish_done(1'b0, 8'hF0);
        checks++; if ({done, err, rdata} !== {8'h01, 8'h00, 8'hF0})
            $display("FAIL single_done: got %h expected %h", {done, err, rdata}, {8'h01, 8'h00, 8'hF0}); else passes++;
        req = 8'h00;
        step();
        checks++; if ({gnt, done} !== 16'h0) $display("FAIL single_release: got %h expected 0000", {gnt, done}); else passes++;
        checks++; if (start_pulses - s0 !== 1) $display("FAIL single_start_count: got %0d expected 1", start_pulses - s0); else passes++;
        mdl_ptr = 1; mdl_rdata = 8'hF0;
    endtask

    task automatic test_nack();
        int c;
        logic [7:0] rd;
        rand_fields();
        f_rnw[3] = 1'b0;
        drive_fields();
        req = 8'h08;
        wait_gnt(c);
        checks++; if (gnt !== 8'h08) $display("FAIL nack_gnt: got %h expected 08", gnt); else passes++;
        checks++; if ({m_rnw, m_wdata} !== {1'b0, f_wd[3]}) $display("FAIL nack_cmd: got %h expected %h", {m_rnw, m_wdata}, {1'b0, f_wd[3]}); else passes++;
        wait_start(c);
        step();
        rd = ~mdl_rdata;
        finish_done(1'b1, rd);
        checks++; if ({done, err} !== 16'h0808) $display("FAIL nack_done_err: got %h expected 0808", {done, err}); else passes++;
        checks++; if (rdata !== mdl_rdata) $display("FAIL nack_rdata: got %h expected %h", rdata, mdl_rdata); else passes++;
        req = 8'h00;
        step();
        mdl_ptr = 4;
    endtask

    task automatic test_busy();
        int c, s0, bad, s;
        logic [7:0] rd;
        s = $urandom_range(0, 7);
        rand_fields();
        m_busy = 1'b1;
        req = 8'b1 << s;
        wait_gnt(c);
        checks++; if (gnt !== (8'b1 << s)) $display("FAIL busy_gnt: got %h expected %h", gnt, 8'b1 << s); else passes++;
        s0 = start_pulses;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_start !== 1'b0 || done !== 8'h00) bad++;
            m_done = (i == 4); m_ack_err = (i == 4); m_rdata = 8'hAA;
            step();
            m_done = 1'b0; m_ack_err = 1'b0;
        end
        if (m_start !== 1'b0 || done !== 8'h00) bad++;
        checks++; if (bad !== 0) $display("FAIL busy_hold_low: got %0d bad cycles expected 0", bad); else passes++;
        m_busy = 1'b0;
        step();
        checks++; if (m_start !== 1'b1) $display("FAIL busy_start_pulse: got %b expected 1", m_start); else passes++;
        step();
        checks++; if (m_start !== 1'b0) $display("FAIL busy_start_width: got %b expected 0", m_start); else passes++;
        rd = 8'($urandom);
        finish_done(1'b0, rd);
        if (f_rnw[s]) mdl_rdata = rd;
        checks++; if ({done, err, rdata} !== {8'b1 << s, 8'h00, mdl_rdata})
            $display("FAIL busy_done: got %h expected %h", {done, err, rdata}, {8'b1 << s, 8'h00, mdl_rdata}); else passes++;
        checks++; if (start_pulses - s0 !== 1) $display("FAIL busy_start_count: got %0d expected 1", start_pulses - s0); else passes++;
        req = 8'h00;
        step();
        mdl_ptr = (s + 1) % 8;
    endtask

    task automatic test_timeout();
        int c, s;
        s = $urandom_range(0, 7);
        rand_fields();
        req = 8'b1 << s;
        wait_gnt(c);
        wait_start(c);
        wait_done(c);
        checks++; if (c !== TO) $display("FAIL timeout_latency: got %0d expected %0d", c, TO); else passes++;
        checks++; if ({done, err} !== {8'b1 << s, 8'b1 << s}) $display("FAIL timeout_done_err: got %h expected %h", {done, err}, {8'b1 << s, 8'b1 << s}); else passes++;
        checks++; if (rdata !== mdl_rdata) $display("FAIL timeout_rdata: got %h expected %h", rdata, mdl_rdata); else passes++;
        req = 8'h00;
        step();
        checks++; if (gnt !== 8'h00) $display("FAIL timeout_release: got %h expected 00", gnt); else passes++;
        finish_done(1'b1, 8'h5A);
        checks++; if ({gnt, done, err} !== 24'h0) $display("FAIL idle_done_ignored: got %h expected 0", {gnt, done, err}); else passes++;
        mdl_ptr = (s + 1) % 8;
    endtask

    task automatic test_done_at_timeout();
        int c, s;
        logic [7:0] rd;
        s = $urandom_range(0, 7);
        rand_fields();
        f_rnw[s] = 1'b1;
        drive_fields();
        req = 8'b1 << s;
        wait_gnt(c);
        wait_start(c);
        repeat (TO - 1) step();
        rd = 8'($urandom);
        finish_done(1'b0, rd);
        checks++; if ({done, err, rdata} !== {8'b1 << s, 8'h00, rd})
            $display("FAIL done_beats_timeout: got %h expected %h", {done, err, rdata}, {8'b1 << s, 8'h00, rd}); else passes++;
        req = 8'h00;
        step();
        mdl_rdata = rd; mdl_ptr = (s + 1) % 8;
    endtask

    task automatic test_random();
        int c, w, b, d;
        logic [7:0] r, rd;
        logic ack;
        logic [31:0] exp_cmd;
        for (int it = 0; it < 40; it++) begin
            r = 8'($urandom_range(1, 255));
            rand_fields();
            w = rr_pick(r, mdl_ptr);
            exp_cmd = {f_rnw[w], f_dev[w], f_reg[w], f_wd[w]};
            req = r;
            wait_gnt(c);
            checks++; if (gnt !== (8'b1 << w) || c !== 1) $display("FAIL rand_gnt[%0d]: got %h after %0d expected %h after 1", it, gnt, c, 8'b1 << w); else passes++;
            checks++; if ({m_rnw, m_dev_addr, m_reg_addr, m_wdata, cur_owner} !== {exp_cmd, 3'(w)})
                $display("FAIL rand_cmd[%0d]: got %h expected %h", it, {m_rnw, m_dev_addr, m_reg_addr, m_wdata, cur_owner}, {exp_cmd, 3'(w)}); else passes++;
            b = $urandom_range(0, 3);
            m_busy = (b != 0);
            repeat (b) step();
            m_busy = 1'b0;
            wait_start(c);
            rand_fields();
            req = 8'($urandom);
            d = $urandom_range(0, 19);
            ack = 1'($urandom);
            rd = 8'($urandom);
            if (d < TO) begin
                repeat (d) step();
                finish_done(ack, rd);
                if (exp_cmd[31]) mdl_rdata = rd;
                checks++; if ({done, err, rdata} !== {8'b1 << w, ack ? 8'b1 << w : 8'h00, mdl_rdata})
                    $display("FAIL rand_done[%0d]: got %h expected %h", it, {done, err, rdata}, {8'b1 << w, ack ? 8'b1 << w : 8'h00, mdl_rdata}); else passes++;
            end else begin
                wait_done(c);
                checks++; if ({done, err, rdata} !== {8'b1 << w, 8'b1 << w, mdl_rdata} || c !== TO)
                    $display("FAIL rand_timeout[%0d]: got %h after %0d expected %h after %0d", it, {done, err, rdata}, c, {8'b1 << w, 8'b1 << w, mdl_rdata}, TO); else passes++;
            end
            checks++; if ({m_rnw, m_dev_addr, m_reg_addr, m_wdata} !== exp_cmd)
                $display("FAIL rand_cmd_hold[%0d]: got %h expected %h", it, {m_rnw, m_dev_addr, m_reg_addr, m_wdata}, exp_cmd); else passes++;
            req = 8'h00;
            step();
            mdl_ptr = (w + 1) % 8;
        end
    endtask

    task automatic test_contention();
        int c;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        mdl_rdata = 8'h00;
        rand_fields();
        req = 8'hFF;
        wait_gnt(c);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                step();
                checks++; if (gnt !== 8'h00) $display("FAIL contention_gap[%0d]: got %h expected 00", i, gnt); else passes++;
                step();
            end
            checks++; if (gnt !== (8'b1 << (i % 8))) $display("FAIL contention_order[%0d]: got %h expected %h", i, gnt, 8'b1 << (i % 8)); else passes++;
            wait_start(c);
            repeat ($urandom_range(0, 4)) step();
            finish_done(1'b0, 8'($urandom));
            checks++; if (done !== (8'b1 << (i % 8))) $display("FAIL contention_done[%0d]: got %h expected %h", i, done, 8'b1 << (i % 8)); else passes++;
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_wait();
        int c, bad;
        rand_fields();
        req = 8'h20;
        wait_gnt(c);
        checks++; if (gnt !== 8'h20) $display("FAIL rstwait_gnt: got %h expected 20", gnt); else passes++;
        wait_start(c);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++; if ({gnt, done, err, rdata, cur_owner, m_start, m_rnw, m_dev_addr, m_reg_addr, m_wdata} !== 68'h0)
            $display("FAIL rstwait_outputs: got %h expected 0", {gnt, done, err, rdata, cur_owner, m_start, m_rnw, m_dev_addr, m_reg_addr, m_wdata}); else passes++;
        bad = 0;
        m_done = 1'b1;
        repeat (3) begin step(); if (done !== 8'h00 || err !== 8'h00) bad++; end
        m_done = 1'b0;
        checks++; if (bad !== 0) $display("FAIL rstwait_no_done: got %0d pulses expected 0", bad); else passes++;
        req = 8'h21;
        rst_n = 1'b1;
        wait_gnt(c);
        checks++; if (gnt !== 8'h01) $display("FAIL rstwait_first_gnt: got %h expected 01", gnt); else passes++;
        wait_start(c);
        finish_done(1'b0, 8'h00);
        req = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_nack();
        test_busy();
        test_timeout();
        test_done_at_timeout();
        test_random();
        test_contention();
        test_reset_mid_wait();
        checks++; if (inv_bad !== 0) $display("FAIL onehot_owner_invariant: got %0d violations expected 0", inv_bad); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tof_i2c_arbiter.md
TOF_I2C_ARBITER -- requirements
Module: tof_i2c_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 8, the number of ToF sensor FSM requesters (fixed at 8 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 65535, the maximum clk cycles spent waiting for m_done before abort.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  8  per-sensor transaction request; bit i = sensor i.
REQ-006 The block SHALL have port req_rnw  input  8  per-sensor direction; 1 = read, 0 = write.
REQ-007 The block SHALL have port req_dev_addr  input  56  per-sensor 7-bit I2C address; sensor i in bits [7i+6:7i].
REQ-008 The block SHALL have port req_reg_addr  input  128  per-sensor 16-bit register address; sensor i in bits [16i+15:16i].
REQ-009 The block SHALL have port req_wdata  input  64  per-sensor write byte; sensor i in bits [8i+7:8i].
REQ-010 The block SHALL have port gnt  output  8  one-hot grant to the current owner.
REQ-011 The block SHALL have port done  output  8  one-cycle completion pulse to the owner.
REQ-012 The block SHALL have port err  output  8  one-cycle error pulse to the owner (NACK or timeout).
REQ-013 The block SHALL have port rdata  output  8  last read byte returned by the I2C master.
REQ-014 The block SHALL have port cur_owner  output  3  index of the current/last owner.
REQ-015 The block SHALL have ports m_start (out 1), m_rnw (out 1), m_dev_addr (out 7), m_reg_addr (out 16), m_wdata (out 8), the command toward the shared I2C master.
REQ-016 The block SHALL have ports m_busy (in 1), m_done (in 1, one-cycle pulse), m_ack_err (in 1, valid with m_done), m_rdata (in 8, valid with m_done).

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT, RELEASE.
REQ-018 IDLE: if req != 0, the block SHALL pick the winner round-robin, searching from index (ptr) upward mod 8, assert gnt[winner] on the next edge, latch the winner's rnw/dev_addr/reg_addr/wdata into m_* and go to START.
REQ-019 START: when m_busy = 0, the block SHALL assert m_start for exactly one cycle and go to WAIT; while m_busy = 1 it SHALL stay in START with m_start = 0.
REQ-020 WAIT: the block SHALL count cycles from 0; on m_done it SHALL latch m_rdata into rdata (reads only), pulse done[owner], pulse err[owner] if m_ack_err = 1, and go to RELEASE.
REQ-021 WAIT: if the count reaches TIMEOUT_CYC without m_done, the block SHALL pulse done[owner] and err[owner] together and go to RELEASE; rdata SHALL remain unchanged.
REQ-022 If m_done arrives in the same cycle the count reaches TIMEOUT_CYC, m_done SHALL take precedence (err = m_ack_err).
REQ-023 RELEASE: the block SHALL clear gnt, set ptr = (owner + 1) mod 8 and return to IDLE; each transaction therefore has at least one idle cycle between grants.
REQ-024 The owner's request fields and req bit SHALL be ignored between latch and RELEASE; deasserting req mid-transaction SHALL NOT abort it.
REQ-025 A requester still holding req after its done SHALL re-arbitrate at lowest priority.
REQ-026 m_done outside WAIT SHALL be ignored.
REQ-027 gnt SHALL be one-hot or zero at all times; done and err SHALL only ever target the owner bit.
REQ-028 Minimum latency: req rise at edge N -> gnt at N+1 -> m_start at N+2 (m_busy = 0).

Reset
REQ-029 While rst_n = 0, the block SHALL force state IDLE, ptr = 0, gnt = 0, done = 0, err = 0, rdata = 0, cur_owner = 0, m_start = 0, m_rnw = 0, m_dev_addr = 0, m_reg_addr = 0, m_wdata = 0, timeout count = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it without any done/err pulse; first post-reset grant SHALL use ptr = 0.

Verification
REQ-031 Single request: req = 8'h01, dev_addr[6:0] = 7'h29, reg_addr = 16'h0000, rnw = 1; m_done with m_rdata = 8'hF0 -> gnt = 8'h01, one m_start, m_dev_addr = 7'h29, done[0] pulse, rdata = 8'hF0.
REQ-032 Contention: req = 8'hFF held continuously -> grants in order 0,1,...,7,0 with one idle cycle between each.
REQ-033 NACK: sensor 3 write, m_done with m_ack_err = 1 -> done[3] and err[3] pulse in the same cycle, rdata unchanged.
REQ-034 Timeout: TIMEOUT_CYC = 16, m_done never asserted -> done[owner] and err[owner] pulse 16 cycles after entry to WAIT; arbiter returns to IDLE.
REQ-035 Busy master: m_busy = 1 for 10 cycles after grant -> m_start held low, then exactly one pulse on the first cycle m_busy = 0.
REQ-036 Reset mid-WAIT: rst_n low during sensor 5 transaction -> all outputs 0 immediately, no done[5]; after release with req = 8'h21, sensor 0 wins first.
